// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline-control types for the 5-stage MIPS datapath:
// hazard FSM states, hazard rule classification and per-stage enable/flush pair.
package hazard_control_unit_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DWAIT  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef enum logic [1:0] {
        RUN    = ST_RUN,
        DWAIT  = ST_DWAIT,
        HALTED = ST_HALTED
    } hazard_state_t;

    // Winning hazard condition for the current cycle, highest priority first.
    typedef enum logic [2:0] {
        R_FROZEN,
        R_DMISS,
        R_HALT,
        R_REDIRECT,
        R_IMISS,
        R_LOAD_USE,
        R_ADVANCE
    } hazard_rule_t;

    typedef struct packed {
        logic enable;
        logic flush;
    } pipe_ctrl_t;

    function automatic pipe_ctrl_t ctrl(input logic en, input logic fl);
        pipe_ctrl_t c;
        c.enable = en;
        c.flush  = fl;
        return c;
    endfunction

endpackage

// File: rtl/hazard_control_unit_load_use_detect.sv
// Combinational load-use comparator: the load in EX writes a register read by ID.
module load_use_detect
    import hazard_control_unit_pkg::*;
(
    input  logic       dren_ex,
    input  logic [4:0] rt_ex,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    output logic       load_use
);

    // $zero is never a real dependency.
    assign load_use = dren_ex && (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline enable/flush generation with dcache-wait FSM, watchdog and sticky halt.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = 1024,
    parameter int unsigned CNT_W           = 32
)(
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       dREN_ID_EX,
    input  logic [4:0] Rt_ID_EX,
    input  logic [4:0] Rs_IF_ID,
    input  logic [4:0] Rt_IF_ID,
    input  logic       dREN_EX_MEM,
    input  logic       dWEN_EX_MEM,
    input  logic       pc_redirect_EX,
    input  logic       halt_EX_MEM,
    output logic       pc_enable,
    output logic       enable_IF_ID,
    output logic       flush_IF_ID,
    output logic       enable_ID_EX,
    output logic       flush_ID_EX,
    output logic       enable_EX_MEM,
    output logic       flush_EX_MEM,
    output logic       enable_MEM_WB,
    output logic       halted,
    output logic       mem_timeout
`ifdef HAZARD_STATS_EN
   ,output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] dwait_cycles
`endif
);

    localparam int unsigned       WC_W     = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WC_W-1:0]   WD_LIMIT = WC_W'(WATCHDOG_CYCLES);
    localparam logic [WC_W-1:0]   WC_ONE   = WC_W'(1);

    hazard_state_t   state, state_next;
    hazard_rule_t    rule;
    logic [WC_W-1:0] wait_cnt, wait_cnt_next;
    logic            dmiss, load_use;
    pipe_ctrl_t      if_id, id_ex, ex_mem;
    logic            mem_wb_en, pc_en;

    assign dmiss = (dREN_EX_MEM || dWEN_EX_MEM) && !dhit;

    load_use_detect u_load_use (
        .dren_ex  (dREN_ID_EX),
        .rt_ex    (Rt_ID_EX),
        .rs_id    (Rs_IF_ID),
        .rt_id    (Rt_IF_ID),
        .load_use (load_use)
    );

    always_comb begin
        rule = R_ADVANCE;
        if (state == HALTED)       rule = R_FROZEN;
        else if (dmiss)            rule = R_DMISS;
        else if (halt_EX_MEM)      rule = R_HALT;
        else if (pc_redirect_EX)   rule = R_REDIRECT;
        else if (!ihit)            rule = R_IMISS;
        else if (load_use)         rule = R_LOAD_USE;
    end

    always_comb begin
        pc_en     = 1'b1;
        if_id     = ctrl(1'b1, 1'b0);
        id_ex     = ctrl(1'b1, 1'b0);
        ex_mem    = ctrl(1'b1, 1'b0);
        mem_wb_en = 1'b1;
        case (rule)
            R_FROZEN, R_DMISS: begin
                pc_en     = 1'b0;
                if_id     = ctrl(1'b0, 1'b0);
                id_ex     = ctrl(1'b0, 1'b0);
                ex_mem    = ctrl(1'b0, 1'b0);
                mem_wb_en = 1'b0;
            end
            R_HALT: begin
                pc_en  = 1'b0;
                if_id  = ctrl(1'b0, 1'b0);
                id_ex  = ctrl(1'b0, 1'b0);
                ex_mem = ctrl(1'b0, 1'b1);
            end
            R_REDIRECT: begin
                if_id = ctrl(1'b1, 1'b1);
                id_ex = ctrl(1'b1, 1'b1);
            end
            // ID/EX loads a bubble while fetch and decode hold.
            R_IMISS, R_LOAD_USE: begin
                pc_en = 1'b0;
                if_id = ctrl(1'b0, 1'b0);
                id_ex = ctrl(1'b1, 1'b1);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (rule)
            R_FROZEN: ;
            R_DMISS: begin
                state_next = DWAIT;
                if (state == DWAIT && wait_cnt != WD_LIMIT)
                    wait_cnt_next = wait_cnt + WC_ONE;
            end
            R_HALT: begin
                state_next    = HALTED;
                wait_cnt_next = '0;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (wait_cnt_next == WD_LIMIT)
                mem_timeout <= 1'b1;
        end
    end

    assign pc_enable     = pc_en;
    assign enable_IF_ID  = if_id.enable;
    assign flush_IF_ID   = if_id.flush;
    assign enable_ID_EX  = id_ex.enable;
    assign flush_ID_EX   = id_ex.flush;
    assign enable_EX_MEM = ex_mem.enable;
    assign flush_EX_MEM  = ex_mem.flush;
    assign enable_MEM_WB = mem_wb_en;
    assign halted        = (state == HALTED);

`ifdef HAZARD_STATS_EN
    // R_FROZEN matches none of these, so counters hold while halted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
            flush_events <= '0;
            dwait_cycles <= '0;
        end else begin
            if ((rule == R_IMISS || rule == R_LOAD_USE) && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (rule == R_REDIRECT && flush_events != '1)
                flush_events <= flush_events + CNT_W'(1);
            if (rule == R_DMISS && dwait_cycles != '1)
                dwait_cycles <= dwait_cycles + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed plus randomized bench for hazard_control_unit against a behavioural model.
module tb_hazard_control_unit;

    localparam int WD    = 4;
    localparam int CNT_W = 32;

    logic       CLK;
    logic       nRST;
    logic       ihit, dhit, dREN_ID_EX, dREN_EX_MEM, dWEN_EX_MEM, pc_redirect_EX, halt_EX_MEM;
    logic [4:0] Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
    logic       pc_enable, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX;
    logic       enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, halted, mem_timeout;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cycles, flush_events, dwait_cycles;
`endif

    int passed = 0;
    int total  = 0;

    // Behavioural model: sticky halt, wait episode, watchdog count, counters.
    bit     m_halted, m_wait, m_to;
    int     m_cnt;
    longint m_stall, m_flush, m_dwait;

    hazard_control_unit #(.WATCHDOG_CYCLES(WD), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dREN_ID_EX(dREN_ID_EX), .Rt_ID_EX(Rt_ID_EX), .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID),
        .dREN_EX_MEM(dREN_EX_MEM), .dWEN_EX_MEM(dWEN_EX_MEM),
        .pc_redirect_EX(pc_redirect_EX), .halt_EX_MEM(halt_EX_MEM),
        .pc_enable(pc_enable), .enable_IF_ID(enable_IF_ID), .flush_IF_ID(flush_IF_ID),
        .enable_ID_EX(enable_ID_EX), .flush_ID_EX(flush_ID_EX),
        .enable_EX_MEM(enable_EX_MEM), .flush_EX_MEM(flush_EX_MEM),
        .enable_MEM_WB(enable_MEM_WB), .halted(halted), .mem_timeout(mem_timeout)
`ifdef HAZARD_STATS_EN
       ,.stall_cycles(stall_cycles), .flush_events(flush_events), .dwait_cycles(dwait_cycles)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // 0 halted, 1 dcache miss, 2 halt, 3 redirect, 4 imiss, 5 load-use, 6 advance
    function automatic int classify();
        if (m_halted) return 0;
        if ((dREN_EX_MEM || dWEN_EX_MEM) && !dhit) return 1;
        if (halt_EX_MEM) return 2;
        if (pc_redirect_EX) return 3;
        if (!ihit) return 4;
        if (dREN_ID_EX && Rt_ID_EX != 5'd0 && (Rt_ID_EX == Rs_IF_ID || Rt_ID_EX == Rt_IF_ID)) return 5;
        return 6;
    endfunction

    // {pc, en_ifid, fl_ifid, en_idex, fl_idex, en_exmem, fl_exmem, en_memwb, halted}
    function automatic logic [8:0] expect_of(input int r);
        case (r)
            0:       return 9'b000000001;
            1:       return 9'b000000000;
            2:       return 9'b000000110;
            3:       return 9'b111111010;
            4, 5:    return 9'b000111010;
            default: return 9'b110101010;
        endcase
    endfunction

    function automatic longint sat_inc(input longint v);
        longint maxv;
        maxv = (64'd1 << CNT_W) - 1;
        return (v < maxv) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_halted = 0; m_wait = 0; m_to = 0; m_cnt = 0;
        m_stall = 0; m_flush = 0; m_dwait = 0;
    endtask

    task automatic set_in(input logic ih, input logic dh, input logic ld, input logic [4:0] rte,
                          input logic [4:0] rs, input logic [4:0] rt, input logic rd,
                          input logic wr, input logic redir, input logic hlt);
        ihit = ih; dhit = dh; dREN_ID_EX = ld; Rt_ID_EX = rte; Rs_IF_ID = rs; Rt_IF_ID = rt;
        dREN_EX_MEM = rd; dWEN_EX_MEM = wr; pc_redirect_EX = redir; halt_EX_MEM = hlt;
    endtask

    task automatic check_outputs(input string tag);
        logic [8:0] got, exp;
        exp = expect_of(classify());
        got = {pc_enable, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX,
               enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, halted};
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s ctrl: got %b expected %b", tag, got, exp);
        total++;
        assert (mem_timeout === m_to) passed++;
        else $error("FAIL %s mem_timeout: got %b expected %b", tag, mem_timeout, m_to);
`ifdef HAZARD_STATS_EN
        total++;
        assert ({stall_cycles, flush_events, dwait_cycles} === {CNT_W'(m_stall), CNT_W'(m_flush), CNT_W'(m_dwait)}) passed++;
        else $error("FAIL %s stats: got %0d/%0d/%0d expected %0d/%0d/%0d", tag,
                    stall_cycles, flush_events, dwait_cycles, m_stall, m_flush, m_dwait);
`endif
    endtask

    // Called just after a falling edge with inputs applied; advances one clock.
    task automatic step(input string tag);
        int r;
        #1;
        check_outputs(tag);
        r = classify();
        @(posedge CLK);
        case (r)
            0: ;
            1: begin
                if (m_wait && m_cnt < WD) m_cnt++;
                if (m_cnt == WD) m_to = 1;
                m_wait  = 1;
                m_dwait = sat_inc(m_dwait);
            end
            default: begin
                m_wait = 0;
                m_cnt  = 0;
                if (r == 2) m_halted = 1;
                if (r == 3) m_flush = sat_inc(m_flush);
                if (r == 4 || r == 5) m_stall = sat_inc(m_stall);
            end
        endcase
        @(negedge CLK);
    endtask

    // Asynchronous reset pulse inside the low clock phase.
    task automatic do_reset(input string tag);
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        int halt_steps;
        int burst;
        logic ld, rd, wr;

        model_reset();
        nRST = 1'b0;
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check_outputs("reset");
        @(negedge CLK);
        nRST = 1'b1;

        // Load-use: one bubble, then the load leaves EX
        set_in(1, 1, 1, 5, 5, 3, 0, 0, 0, 0);  step("lu_rs");
        set_in(1, 1, 0, 5, 5, 3, 0, 0, 0, 0);  step("lu_after");
        set_in(1, 1, 1, 7, 2, 7, 0, 0, 0, 0);  step("lu_rt");
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);  step("lu_r0");
        // Branch overriding icache miss, then plain imiss
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);  step("redir_imiss");
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("imiss");
        // Three-cycle dcache miss, then completion
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); step("dmiss");
        end
        set_in(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);  step("dmiss_done");
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("idle");
        // Watchdog: six miss cycles, flag stays after completion
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 0, 1, 0, 0); step("wdog");
        end
        set_in(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);  step("wdog_done");
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("wdog_sticky");
        do_reset("reset_wdog");
        // Reset in the middle of a wait episode
        set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);  step("dmiss2");
        set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);  step("dmiss2");
        do_reset("reset_dwait");
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("after_reset");
        // Halt, then hold through a redirect, then reset
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);  step("halt");
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);  step("halted_redir");
        set_in(1, 0, 1, 5, 5, 0, 1, 0, 1, 1);  step("halted_all");
        do_reset("reset_halt");
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);  step("run_again");

        // Randomized phase with miss bursts, rare halts and resets
        halt_steps = 0;
        burst = 0;
        for (int n = 0; n < 600; n++) begin
            if (burst == 0 && $urandom_range(0, 11) == 0) burst = int'($urandom_range(1, 7));
            ld = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 1) == 0);
            wr = !rd && ($urandom_range(0, 1) == 0);
            if (burst > 0 && !rd && !wr) rd = 1'b1;
            set_in($urandom_range(0, 7) != 0, burst == 0, ld,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   rd, wr, $urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0);
            if (burst > 0) burst--;
            step("rand");
            if (m_halted) halt_steps++;
            if (halt_steps >= 3 || $urandom_range(0, 150) == 0) begin
                halt_steps = 0;
                burst = 0;
                do_reset("rand_reset");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
